// File: rtl/grid_pio_irq.sv
// grid_pio_irq: parametrised GPIO port on an Avalon-MM slave. It provides input
// synchronisers, atomic set/clear of the output data, and per-pin edge capture
// that drives a maskable level interrupt.
module grid_pio_irq #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             csi_MCLK_clk,
    input  logic             rsi_MRST_reset,
    input  logic [4:0]       avs_gpio_address,
    input  logic [31:0]      avs_gpio_writedata,
    input  logic [3:0]       avs_gpio_byteenable,
    input  logic             avs_gpio_write,
    input  logic             avs_gpio_read,
    output logic [31:0]      avs_gpio_readdata,
    output logic             avs_gpio_waitrequest,
    output logic             ins_INTRQ_irq,
    inout  wire  [WIDTH-1:0] coe_pio
);

    localparam logic [31:0] IdWord = {16'h5049, 8'd0, 8'(WIDTH)};

    logic [WIDTH-1:0] io_data_q, io_data_d;
    logic [WIDTH-1:0] io_oe_q, io_oe_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] prev_in_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_in;
    logic [31:0]      readdata_q;
    logic [31:0]      rd_word;
    logic [31:0]      be_mask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] ecap_clr;
    logic [WIDTH-1:0] edge_hit;

    assign avs_gpio_waitrequest = 1'b0;
    assign avs_gpio_readdata    = readdata_q;
    assign sync_in              = sync_q[SYNC_STAGES-1];

    // Tristate pin drivers: each pin is driven only when its output enable is set.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign coe_pio[i] = io_oe_q[i] ? io_data_q[i] : 1'bz;
    end

    // Expand the byte enables into a bit mask that is truncated to the port width.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            be_mask[8*n +: 8] = {8{avs_gpio_byteenable[n]}};
        end
        wmask = be_mask[WIDTH-1:0];
        wbits = avs_gpio_writedata[WIDTH-1:0] & wmask;
    end

    // Edge detection on the synchronised inputs.
    always_comb begin
        edge_hit = (sync_in & ~prev_in_q & rise_en_q) | (~sync_in & prev_in_q & fall_en_q);
    end

    // Register write decode. A newly captured edge overrides a W1C on the same bit.
    always_comb begin
        io_data_d  = io_data_q;
        io_oe_d    = io_oe_q;
        irq_mask_d = irq_mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        ecap_clr   = '0;
        if (avs_gpio_write) begin
            case (avs_gpio_address)
                5'd0:    io_data_d  = (io_data_q & ~wmask) | wbits;
                5'd1:    io_oe_d    = (io_oe_q & ~wmask) | wbits;
                5'd2:    io_data_d  = io_data_q | wbits;
                5'd3:    io_data_d  = io_data_q & ~wbits;
                5'd4:    irq_mask_d = (irq_mask_q & ~wmask) | wbits;
                5'd5:    ecap_clr   = wbits;
                5'd6:    rise_en_d  = (rise_en_q & ~wmask) | wbits;
                5'd7:    fall_en_d  = (fall_en_q & ~wmask) | wbits;
                default: ;
            endcase
        end
        edge_cap_d = (edge_cap_q & ~ecap_clr) | edge_hit;
    end

    // Read mux built from current register values, so a same-cycle write is not visible.
    always_comb begin
        rd_word = '0;
        case (avs_gpio_address)
            5'd0:    rd_word[WIDTH-1:0] = sync_in;
            5'd1:    rd_word[WIDTH-1:0] = io_oe_q;
            5'd4:    rd_word[WIDTH-1:0] = irq_mask_q;
            5'd5:    rd_word[WIDTH-1:0] = edge_cap_q;
            5'd6:    rd_word[WIDTH-1:0] = rise_en_q;
            5'd7:    rd_word[WIDTH-1:0] = fall_en_q;
            5'd8:    rd_word = IdWord;
            default: rd_word = '0;
        endcase
    end

    // State registers, the input synchroniser chain and the registered read data.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            io_data_q  <= '0;
            io_oe_q    <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            prev_in_q  <= '0;
            sync_q     <= '0;
            readdata_q <= '0;
        end else begin
            io_data_q  <= io_data_d;
            io_oe_q    <= io_oe_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            prev_in_q  <= sync_in;
            sync_q[0]  <= coe_pio;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            if (avs_gpio_read) begin
                readdata_q <= rd_word;
            end
        end
    end

    // The interrupt is decoded directly from the registers, with no extra flop.
    always_comb begin
        ins_INTRQ_irq = |(edge_cap_q & irq_mask_q);
    end

endmodule

// File: tb/tb_grid_pio_irq.sv
// tb_grid_pio_irq: directed self-checking bench for grid_pio_irq (WIDTH=26, SYNC_STAGES=2).
module tb_grid_pio_irq;

    localparam int unsigned W = 26;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        irq;
    wire  [W-1:0] pio;
    logic [W-1:0] tb_en = '0;
    logic [W-1:0] tb_val = '0;
    logic [31:0] rd;
    int          n_checks = 0;
    int          n_pass = 0;

    // Bench-side pin drivers, enabled per bit.
    for (genvar i = 0; i < W; i++) begin : g_drv
        assign pio[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    grid_pio_irq #(
        .WIDTH       (W),
        .SYNC_STAGES (2)
    ) dut (
        .csi_MCLK_clk         (clk),
        .rsi_MRST_reset       (rst),
        .avs_gpio_address     (address),
        .avs_gpio_writedata   (writedata),
        .avs_gpio_byteenable  (byteenable),
        .avs_gpio_write       (write),
        .avs_gpio_read        (read),
        .avs_gpio_readdata    (readdata),
        .avs_gpio_waitrequest (waitrequest),
        .ins_INTRQ_irq        (irq),
        .coe_pio              (pio)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        @(posedge clk);
        #1;
        write      = 1'b0;
        byteenable = '0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
        d    = readdata;
    endtask

    initial begin
        // Reset state.
        #12;
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        check_eq("rst_readdata", readdata, 32'd0);
        check_eq("waitrequest", {31'd0, waitrequest}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);

        // Pins pulled externally, then DATA and ID reads.
        tb_en  = '1;
        tb_val = 26'h2AAAAAA;
        tick(3);
        bus_read(5'd0, rd);
        check_eq("data_pulled", rd, 32'h02AAAAAA);
        bus_read(5'd8, rd);
        check_eq("id", rd, 32'h5049001A);
        tb_en = '0;

        // Output control with atomic set/clear.
        bus_write(5'd1, 32'hFFFFFFFF, 4'hF);
        bus_read(5'd1, rd);
        check_eq("oe_width", rd, 32'h03FFFFFF);
        bus_write(5'd0, 32'h00000F0F, 4'hF);
        check_eq("pins_data", {6'd0, pio}, 32'h00000F0F);
        bus_write(5'd2, 32'h00F00000, 4'hF);
        check_eq("pins_set", {6'd0, pio}, 32'h00F00F0F);
        tick(3);
        bus_read(5'd0, rd);
        check_eq("data_after_set", rd, 32'h00F00F0F);
        bus_write(5'd3, 32'h0000000F, 4'hF);
        check_eq("pins_clr", {6'd0, pio}, 32'h00F00F00);
        tick(3);
        bus_read(5'd0, rd);
        check_eq("data_after_clr", rd, 32'h00F00F00);

        // Byte-lane write.
        bus_write(5'd1, 32'h00000000, 4'hF);
        bus_write(5'd1, 32'h00FF00FF, 4'b0100);
        bus_read(5'd1, rd);
        check_eq("oe_byteenable", rd, 32'h00FF0000);
        bus_write(5'd1, 32'h00000000, 4'hF);

        // Rising edge on pin 3 with interrupt enabled; pin 5 starts high.
        tb_en  = '1;
        tb_val = 26'h0000020;
        tick(4);
        bus_read(5'd5, rd);
        check_eq("ecap_idle", rd, 32'd0);
        bus_write(5'd6, 32'h00000008, 4'hF);
        bus_write(5'd4, 32'h00000008, 4'hF);
        tb_val[3] = 1'b1;
        tick(1);
        check_eq("rise_k0_irq", {31'd0, irq}, 32'd0);
        tick(1);
        check_eq("rise_k1_irq", {31'd0, irq}, 32'd0);
        tick(1);
        check_eq("rise_k2_irq", {31'd0, irq}, 32'd1);
        bus_read(5'd5, rd);
        check_eq("rise_ecap", rd, 32'h00000008);
        bus_write(5'd5, 32'h00000008, 4'hF);
        check_eq("w1c_irq", {31'd0, irq}, 32'd0);

        // Falling edge on pin 5 while masked, then unmasked.
        bus_write(5'd7, 32'h00000020, 4'hF);
        bus_write(5'd4, 32'h00000000, 4'hF);
        tb_val[5] = 1'b0;
        tick(4);
        bus_read(5'd5, rd);
        check_eq("fall_ecap", rd, 32'h00000020);
        check_eq("fall_masked_irq", {31'd0, irq}, 32'd0);
        bus_write(5'd4, 32'h00000020, 4'hF);
        check_eq("fall_unmask_irq", {31'd0, irq}, 32'd1);
        bus_write(5'd5, 32'h00000020, 4'hF);
        check_eq("fall_clr_irq", {31'd0, irq}, 32'd0);

        // W1C landing on the same edge as a new capture on pin 3.
        bus_write(5'd4, 32'h00000008, 4'hF);
        tb_val[3] = 1'b0;
        tick(4);
        check_eq("coll_pre_irq", {31'd0, irq}, 32'd0);
        tb_val[3] = 1'b1;
        tick(4);
        check_eq("coll_first_irq", {31'd0, irq}, 32'd1);
        tb_val[3] = 1'b0;
        tick(4);
        tb_val[3] = 1'b1;
        tick(2);
        bus_write(5'd5, 32'h00000008, 4'hF);
        check_eq("coll_irq", {31'd0, irq}, 32'd1);
        bus_read(5'd5, rd);
        check_eq("coll_ecap", rd, 32'h00000008);

        // Asynchronous reset in the middle of a write.
        bus_write(5'd6, 32'h00000000, 4'hF);
        address    = 5'd1;
        writedata  = 32'hFFFFFFFF;
        byteenable = 4'hF;
        write      = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        check_eq("midrst_irq", {31'd0, irq}, 32'd0);
        check_eq("midrst_readdata", readdata, 32'd0);
        @(posedge clk);
        #1;
        write = 1'b0;
        rst   = 1'b0;
        bus_read(5'd1, rd);
        check_eq("midrst_oe", rd, 32'd0);
        bus_read(5'd4, rd);
        check_eq("midrst_mask", rd, 32'd0);
        bus_read(5'd5, rd);
        check_eq("midrst_ecap", rd, 32'd0);
        tb_val = 26'h2AAAAAA;
        tick(3);
        check_eq("midrst_pins", {6'd0, pio}, 32'h02AAAAAA);
        bus_read(5'd0, rd);
        check_eq("midrst_data", rd, 32'h02AAAAAA);
        check_eq("midrst_irq_end", {31'd0, irq}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/grid_pio_irq.md
Name: grid_pio_irq

Overview:
- Parametrised general-purpose I/O port with an Avalon-MM slave, generalised from 26 fixed pins to WIDTH bidirectional pins.
- Adds three things over the fixed-pin port: metastability synchronisers on inputs; atomic set/clear of output data; per-pin rising/falling edge capture with a maskable level interrupt.
- Sits on the system interconnect as a CPU-controlled peripheral driving board pins.

Parameters:
- WIDTH, 32, number of pins, legal range 1..32; register bits at and above WIDTH read 0 and ignore writes.
- SYNC_STAGES, 2, input synchroniser depth, legal range 2..4.

Ports:
- csi_MCLK_clk  in  1  clock; all logic on the rising edge.
- rsi_MRST_reset  in  1  reset, asynchronous, active-high.
- avs_gpio_address  in  5  word address.
- avs_gpio_writedata  in  32  write data.
- avs_gpio_byteenable  in  4  byte lane enables for writes.
- avs_gpio_write  in  1  write strobe.
- avs_gpio_read  in  1  read strobe.
- avs_gpio_readdata  out  32  read data, fixed read latency 1.
- avs_gpio_waitrequest  out  1  tied 0.
- ins_INTRQ_irq  out  1  level interrupt, active-high.
- coe_pio  inout  WIDTH  pins.

Behaviour:
- Register map (word address):
  - 0 DATA: read returns synchronised pin values; write updates io_data.
  - 1 OE: read/write.
  - 2 SET: write-only; io_data |= wdata.
  - 3 CLR: write-only; io_data &= ~wdata.
  - 4 IRQ_MASK: read/write.
  - 5 EDGE_CAP: read; write-1-to-clear.
  - 6 RISE_EN: read/write.
  - 7 FALL_EN: read/write.
  - 8 ID: read-only constant {16'h5049, 8'd0, WIDTH[7:0]}.
  - Other addresses: reads return 0; writes ignored.
  - SET, CLR and EDGE_CAP writes act only on bits with byteenable set.
- Byteenable: for read/write registers, byte lane n updates bits [8n+7:8n] only when byteenable[n]=1. This applies to every write register.
- Pin drive: coe_pio[i] = io_oe[i] ? io_data[i] : Z.
- Synchroniser: SYNC_STAGES flops per pin, giving sync_in. prev_in holds sync_in delayed by one cycle.
- Edge detect:
  - rise[i] = sync_in[i] & ~prev_in[i] & RISE_EN[i].
  - fall[i] = ~sync_in[i] & prev_in[i] & FALL_EN[i].
  - EDGE_CAP[i] is set on the clock edge where rise|fall is true.
- Simultaneous edge and W1C on the same bit: the set wins, and the bit stays 1.
- Interrupt: ins_INTRQ_irq = |(EDGE_CAP & IRQ_MASK), decoded from registers with no extra delay.
- Latency:
  - A pin transition sampled at clock k appears in sync_in after clock k+SYNC_STAGES-1.
  - EDGE_CAP bit and irq assert after clock k+SYNC_STAGES.
  - A DATA write changes the pin on the clock edge that accepts the write.
- Read: readdata is registered on the clock where avs_gpio_read=1 and is valid the following cycle. It holds its value when read=0.
- Read and write in the same cycle to the same register: read returns the old value.
- Reset (asynchronous, any time, including mid-transaction):
  - io_data, io_oe, IRQ_MASK, EDGE_CAP, RISE_EN, FALL_EN, synchronisers, prev_in and readdata all clear to 0.
  - Consequences: all pins Z, irq = 0.
  - Edge enables at 0 guarantee no spurious capture after reset.
- Width rule: internal registers are WIDTH bits, zero-extended on read. Writedata bits at and above WIDTH are discarded.

Test Plan:
- Reset/ID (WIDTH=26):
  - Assert reset mid-write -> all pins Z, irq=0.
  - Read addr 0 with pins pulled to 26'h2AAAAAA -> readdata 32'h02AAAAAA one cycle after read.
  - Read addr 8 -> 32'h5049001A.
- Output control:
  - Write OE=32'hFFFFFFFF, DATA=32'h00000F0F -> pins 0..3 and 8..11 driven high.
  - SET 32'h00F00000 -> io_data 32'h00F00F0F.
  - CLR 32'h0000000F -> io_data 32'h00F00F00.
  - Bits 26..31 read 0.
- Byteenable: write OE=32'h00FF00FF with byteenable 4'b0100 -> OE reads 32'h00FF0000 (from 0).
- Rising edge interrupt (SYNC_STAGES=2):
  - Set RISE_EN[3]=1 and IRQ_MASK[3]=1, then drive pin3 0->1 sampled at clock k.
  - Required: EDGE_CAP=32'h8 and irq=1 after clock k+2.
  - W1C write of 32'h8 -> irq=0 next cycle.
- Fall edge masked: FALL_EN[5]=1, IRQ_MASK=0, pin5 1->0 -> EDGE_CAP=32'h20, irq stays 0. Then set IRQ_MASK[5] -> irq=1.
- Collision: W1C of bit 3 on the same clock that a new rise on pin3 is captured -> EDGE_CAP[3] remains 1, irq remains 1.
